// File: rtl/eth_phy_10g_pkg.sv
// Shared constants for the 10G PHY SERDES-side helpers: sync headers,
// error-injection mode encodings, injector FSM states and the LFSR polynomial.
package eth_phy_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_HDR_ONES  = 2'd0,
        MODE_HDR_ZEROS = 2'd1,
        MODE_HDR_INV   = 2'd2,
        MODE_DATA_FLIP = 2'd3
    } err_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } inj_state_t;

    function automatic logic [31:0] lfsr32_step(input logic [31:0] s);
        lfsr32_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'd0);
    endfunction

endpackage

// File: rtl/eth_phy_10g_serdes_err_inj_if.sv
// One 66b block stream beat: payload, sync header and a valid qualifier.
interface eth_phy_10g_serdes_err_inj_if #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2
);
    // valid marks a block on data/hdr this cycle; there is no ready, so the
    // consumer must take every beat on which valid is high.
    logic [DATA_WIDTH-1:0] data;
    logic [HDR_WIDTH-1:0]  hdr;
    logic                  valid;

    modport master (output data, output hdr, output valid);
    modport slave  (input data, input hdr, input valid);
endinterface

// File: rtl/eth_phy_10g_lfsr32.sv
// 32-bit Galois LFSR with a conditional advance; rnd is the current
// (pre-advance) state. A zero seed is replaced by 1 so the register never locks up.
module eth_phy_10g_lfsr32
    import eth_phy_10g_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2345
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [31:0] rnd
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = lfsr32_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = lfsr_q;

endmodule

// File: rtl/eth_phy_10g_serdes_err_inj.sv
// SERDES-side 66b block error injector: one-cycle pass-through register with
// LFSR-chosen, optionally bursty header/data corruption and saturating statistics.
module eth_phy_10g_serdes_err_inj
    import eth_phy_10g_pkg::*;
#(
    parameter int          DATA_WIDTH  = 64,
    parameter int          HDR_WIDTH   = 2,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2345,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                    rx_clk,
    input  logic                    rx_rst_n,
    eth_phy_10g_serdes_err_inj_if.slave  in_blk,
    eth_phy_10g_serdes_err_inj_if.master out_blk,
    input  logic                    cfg_enable,
    input  logic [7:0]              cfg_err_thresh,
    input  logic [3:0]              cfg_burst_len,
    input  logic [1:0]              cfg_mode,
    input  logic                    stat_clear,
    output logic [COUNT_WIDTH-1:0]  stat_pass_count,
    output logic [COUNT_WIDTH-1:0]  stat_inject_count,
    output logic                    inject_active,
    output inj_state_t              dbg_state
);

    logic [31:0] rnd;

    eth_phy_10g_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (rx_clk),
        .rst_n   (rx_rst_n),
        .advance (in_blk.valid),
        .rnd     (rnd)
    );

    logic unused_rnd;
    assign unused_rnd = ^{rnd[31:14], rnd[7]};

    inj_state_t state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [3:0] eff_len;
    logic       trigger;
    logic       corrupt;

    assign eff_len = (cfg_burst_len == 4'd0) ? 4'd1 : cfg_burst_len;
    assign trigger = cfg_enable && in_blk.valid &&
                     ({1'b0, rnd[6:0]} < cfg_err_thresh);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        corrupt     = 1'b0;
        if (!cfg_enable) begin
            state_d = ST_IDLE;
        end else if (in_blk.valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        corrupt = 1'b1;
                        if (eff_len > 4'd1) begin
                            state_d     = ST_BURST;
                            remaining_d = eff_len - 4'd1;
                        end
                    end
                end
                ST_BURST: begin
                    corrupt     = 1'b1;
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Corruption mux; the flipped data bit index comes from the same rnd that
    // made the trigger decision, so a reference model can predict it.
    logic [DATA_WIDTH-1:0] out_data_d, out_data_q;
    logic [HDR_WIDTH-1:0]  out_hdr_d, out_hdr_q;
    logic [DATA_WIDTH-1:0] flip_mask;

    assign flip_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << rnd[13:8];

    always_comb begin
        out_data_d = in_blk.data;
        out_hdr_d  = in_blk.hdr;
        if (corrupt) begin
            case (cfg_mode)
                MODE_HDR_ONES:  out_hdr_d  = '1;
                MODE_HDR_ZEROS: out_hdr_d  = '0;
                MODE_HDR_INV:   out_hdr_d  = ~in_blk.hdr;
                MODE_DATA_FLIP: out_data_d = in_blk.data ^ flip_mask;
                default:        out_hdr_d  = in_blk.hdr;
            endcase
        end
    end

    logic [COUNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [COUNT_WIDTH-1:0] inj_cnt_q, inj_cnt_d;

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        inj_cnt_d  = inj_cnt_q;
        if (stat_clear) begin
            pass_cnt_d = '0;
            inj_cnt_d  = '0;
        end else if (in_blk.valid) begin
            if (corrupt) begin
                if (inj_cnt_q != '1) inj_cnt_d = inj_cnt_q + 1'b1;
            end else begin
                if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
            end
        end
    end

    logic out_valid_q;
    logic inject_q;

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= 4'd0;
            out_data_q  <= '0;
            out_hdr_q   <= '0;
            out_valid_q <= 1'b0;
            inject_q    <= 1'b0;
            pass_cnt_q  <= '0;
            inj_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_hdr_q   <= out_hdr_d;
            out_valid_q <= in_blk.valid;
            inject_q    <= corrupt;
            pass_cnt_q  <= pass_cnt_d;
            inj_cnt_q   <= inj_cnt_d;
        end
    end

    assign out_blk.data      = out_data_q;
    assign out_blk.hdr       = out_hdr_q;
    assign out_blk.valid     = out_valid_q;
    assign inject_active     = inject_q;
    assign stat_pass_count   = pass_cnt_q;
    assign stat_inject_count = inj_cnt_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_eth_phy_10g_serdes_err_inj.sv
// Directed bench for the SERDES error injector with a reference LFSR/FSM model
// feeding an expected-output queue; a 4-bit counter build checks saturation.
module tb_eth_phy_10g_serdes_err_inj;
    import eth_phy_10g_pkg::*;

    localparam logic [31:0] SEED = 32'hACE1_2345;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_phy_10g_serdes_err_inj_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) in_if ();
    eth_phy_10g_serdes_err_inj_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) out_if ();
    eth_phy_10g_serdes_err_inj_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) out_if4 ();

    logic        cfg_enable = 1'b0;
    logic [7:0]  cfg_err_thresh = 8'd0;
    logic [3:0]  cfg_burst_len = 4'd0;
    logic [1:0]  cfg_mode = 2'd0;
    logic        stat_clear = 1'b0;
    logic [31:0] stat_pass, stat_inj;
    logic [3:0]  stat_pass4, stat_inj4;
    logic        inject_active, inject_active4;
    inj_state_t  dbg_state, dbg_state4;

    eth_phy_10g_serdes_err_inj #(.LFSR_SEED(SEED)) dut (
        .rx_clk(clk), .rx_rst_n(rst_n), .in_blk(in_if.slave), .out_blk(out_if.master),
        .cfg_enable(cfg_enable), .cfg_err_thresh(cfg_err_thresh), .cfg_burst_len(cfg_burst_len),
        .cfg_mode(cfg_mode), .stat_clear(stat_clear), .stat_pass_count(stat_pass),
        .stat_inject_count(stat_inj), .inject_active(inject_active), .dbg_state(dbg_state)
    );

    eth_phy_10g_serdes_err_inj #(.LFSR_SEED(SEED), .COUNT_WIDTH(4)) dut4 (
        .rx_clk(clk), .rx_rst_n(rst_n), .in_blk(in_if.slave), .out_blk(out_if4.master),
        .cfg_enable(cfg_enable), .cfg_err_thresh(cfg_err_thresh), .cfg_burst_len(cfg_burst_len),
        .cfg_mode(cfg_mode), .stat_clear(stat_clear), .stat_pass_count(stat_pass4),
        .stat_inject_count(stat_inj4), .inject_active(inject_active4), .dbg_state(dbg_state4)
    );

    int checks = 0;
    int errors = 0;

    // Expected entry: {valid, inject, hdr[1:0], data[63:0]}
    logic [67:0] exp_q[$];

    logic [31:0] m_lfsr;
    logic        m_burst;
    logic [3:0]  m_rem;
    logic [31:0] m_pass, m_inj;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = SEED;
        m_burst = 1'b0;
        m_rem   = 4'd0;
        m_pass  = 32'd0;
        m_inj   = 32'd0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n[31] = ~n[31];
            n[21] = ~n[21];
            n[1]  = ~n[1];
            n[0]  = ~n[0];
        end
        return n;
    endfunction

    // Drive one beat (cfg already set by the caller), predict it, then check
    // the registered result half a cycle after the capturing edge.
    task automatic step(input logic v, input logic [63:0] d, input logic [1:0] h);
        logic        corrupt;
        logic [3:0]  len;
        logic [63:0] ed;
        logic [1:0]  eh;
        logic [67:0] e;
        in_if.valid = v;
        in_if.data  = d;
        in_if.hdr   = h;
        corrupt = 1'b0;
        if (!cfg_enable) begin
            m_burst = 1'b0;
        end else if (v) begin
            if (!m_burst) begin
                if ({1'b0, m_lfsr[6:0]} < cfg_err_thresh) begin
                    corrupt = 1'b1;
                    len = (cfg_burst_len == 4'd0) ? 4'd1 : cfg_burst_len;
                    if (len > 4'd1) begin
                        m_burst = 1'b1;
                        m_rem   = len - 4'd1;
                    end
                end
            end else begin
                corrupt = 1'b1;
                m_rem = m_rem - 4'd1;
                if (m_rem == 4'd0) m_burst = 1'b0;
            end
        end
        ed = d;
        eh = h;
        if (corrupt) begin
            case (cfg_mode)
                2'd0: eh = 2'b11;
                2'd1: eh = 2'b00;
                2'd2: eh = {h[0], h[1]} ^ 2'b00 ^ ~{h[1], h[0]} ^ {h[0], h[1]};
                default: ed = d ^ (64'd1 << m_lfsr[13:8]);
            endcase
        end
        if (v) m_lfsr = ref_lfsr(m_lfsr);
        if (stat_clear) begin
            m_pass = 32'd0;
            m_inj  = 32'd0;
        end else if (v) begin
            if (corrupt && m_inj != 32'hFFFF_FFFF) m_inj = m_inj + 1;
            if (!corrupt && m_pass != 32'hFFFF_FFFF) m_pass = m_pass + 1;
        end
        exp_q.push_back({v, corrupt, eh, ed});
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_beat", {out_if.valid, inject_active, out_if.hdr, out_if.data}, e);
        end
        chk("pass_count", {36'd0, stat_pass}, {36'd0, m_pass});
        chk("inject_count", {36'd0, stat_inj}, {36'd0, m_inj});
    endtask

    function automatic logic [1:0] rnd_hdr();
        return ($urandom_range(0, 1) == 0) ? SYNC_DATA : SYNC_CTRL;
    endfunction

    function automatic logic [63:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    logic [63:0] pats [6];
    logic [31:0] inj0, pass0;

    initial begin
        pats[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        pats[1] = 64'h0000_0000_0000_0000;
        pats[2] = 64'h5555_5555_5555_5555;
        pats[3] = 64'hAAAA_AAAA_AAAA_AAAA;
        pats[4] = 64'hFEFE_FEFE_FEFE_FEFE;
        pats[5] = 64'h0707_0707_0707_0707;
        in_if.valid = 1'b0;
        in_if.data  = 64'd0;
        in_if.hdr   = 2'b00;
        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst_out", {out_if.valid, inject_active, out_if.hdr, out_if.data}, 68'd0);
        chk("rst_pass", {36'd0, stat_pass}, 68'd0);
        chk("rst_inj", {36'd0, stat_inj}, 68'd0);
        chk("rst_state", {67'd0, dbg_state}, {67'd0, ST_IDLE});
        rst_n = 1'b1;

        // Injection disabled: pure one-cycle register
        for (int i = 0; i < 1000; i++) step(1'b1, pats[i % 6], (i % 2 == 0) ? 2'b01 : 2'b10);
        chk("dis_pass_1000", {36'd0, stat_pass}, 68'd1000);
        chk("dis_inj_0", {36'd0, stat_inj}, 68'd0);

        // Clear coincident with a valid block: not counted
        stat_clear = 1'b1;
        step(1'b1, pats[2], SYNC_DATA);
        stat_clear = 1'b0;
        chk("clear_wins", {36'd0, stat_pass}, 68'd0);

        // Every block corrupted, header forced to 11
        cfg_enable = 1'b1; cfg_err_thresh = 8'd128; cfg_mode = 2'd0; cfg_burst_len = 4'd1;
        for (int i = 0; i < 24; i++) step((i % 5) != 3, rnd_data(), rnd_hdr());
        chk("all_inj_count", {36'd0, stat_inj}, 68'd19);

        // Statistical injection, header inverted
        cfg_err_thresh = 8'd4; cfg_burst_len = 4'd0; cfg_mode = 2'd2;
        inj0 = stat_inj; pass0 = stat_pass;
        for (int i = 0; i < 10000; i++) step(1'b1, rnd_data(), rnd_hdr());
        chk("ber_range", {67'd0, ((stat_inj - inj0) >= 200) && ((stat_inj - inj0) <= 425)}, 68'd1);
        chk("ber_total", {36'd0, (stat_inj - inj0) + (stat_pass - pass0)}, 68'd10000);

        // Burst of 5 with gaps and a mid-burst length change
        cfg_mode = 2'd0; cfg_burst_len = 4'd5; cfg_err_thresh = 8'd128;
        inj0 = stat_inj;
        step(1'b1, rnd_data(), SYNC_DATA);
        cfg_err_thresh = 8'd0;
        step(1'b0, rnd_data(), SYNC_DATA);
        step(1'b1, rnd_data(), SYNC_CTRL);
        cfg_burst_len = 4'd15;
        step(1'b0, rnd_data(), SYNC_DATA);
        for (int i = 0; i < 10; i++) step(1'b1, rnd_data(), rnd_hdr());
        chk("burst_len5", {36'd0, stat_inj - inj0}, 68'd5);
        chk("burst_done", {67'd0, dbg_state}, {67'd0, ST_IDLE});

        // Single data-bit flip at the LFSR-predicted index
        cfg_mode = 2'd3; cfg_err_thresh = 8'd24; cfg_burst_len = 4'd2;
        for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, rnd_data(), rnd_hdr());

        // Enable dropped mid-burst: current block passes, FSM idles
        cfg_err_thresh = 8'd128; cfg_burst_len = 4'd8; cfg_mode = 2'd1;
        step(1'b1, pats[0], SYNC_DATA);
        cfg_enable = 1'b0;
        step(1'b1, pats[1], SYNC_DATA);
        chk("disable_idle", {67'd0, dbg_state}, {67'd0, ST_IDLE});

        // 4-bit counter build saturates at 15
        stat_clear = 1'b1;
        step(1'b0, pats[0], SYNC_DATA);
        stat_clear = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1, pats[i % 6], SYNC_DATA);
        chk("sat_pass4", {64'd0, stat_pass4}, 68'd15);
        chk("sat_inj4", {64'd0, stat_inj4}, 68'd0);

        // Reset mid-burst, twice, each followed by the same stimulus
        for (int run = 0; run < 2; run++) begin
            cfg_enable = 1'b1; cfg_err_thresh = 8'd128; cfg_burst_len = 4'd10; cfg_mode = 2'd2;
            step(1'b1, pats[2], SYNC_DATA);
            cfg_err_thresh = 8'd6;
            step(1'b1, pats[3], SYNC_CTRL);
            #1 rst_n = 1'b0;
            #1;
            chk("rst_mid_out", {out_if.valid, inject_active, out_if.hdr, out_if.data}, 68'd0);
            chk("rst_mid_state", {67'd0, dbg_state}, {67'd0, ST_IDLE});
            chk("rst_mid_inj", {36'd0, stat_inj}, 68'd0);
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
            cfg_burst_len = 4'd3;
            for (int i = 0; i < 200; i++) step(1'b1, pats[i % 6], (i % 3 == 0) ? SYNC_CTRL : SYNC_DATA);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
